// File: rtl/fc_init_seq_pkg.sv
// Shared types and helpers for the fuse-controller partition init sequencer.
package fc_init_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone,
      StError
   } fc_init_state_e;

   typedef enum logic [1:0] {
      NoErr    = 2'd0,
      PartErr  = 2'd1,
      Timeout  = 2'd2,
      Escalate = 2'd3
   } fc_init_err_e;

   // Corrupted multi-bit encodings must count as escalation, so only exact Off passes.
   function automatic logic lc_tx_is_off(lc_ctrl_pkg::lc_tx_t val);
      return val == lc_ctrl_pkg::Off;
   endfunction

endpackage

// File: rtl/lc_ctrl_pkg.sv
// Life-cycle controller multi-bit signal encoding shared with the fuse controller.
// Only Off means deasserted; every other pattern is treated as asserted by consumers.
package lc_ctrl_pkg;

   typedef enum logic [3:0] {
      On  = 4'b0101,
      Off = 4'b1010
   } lc_tx_t;

endpackage

// File: rtl/fc_init_timeout_cnt.sv
// Saturating watchdog counter with synchronous clear; expired is high once the
// count has reached MAX_COUNT and stays there until cleared.
module fc_init_timeout_cnt #(
   parameter int unsigned MAX_COUNT = 1023,
   localparam int unsigned CNT_W = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && !expired) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (count_q == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/fc_partition_init_seq.sv
// Walks the OTP partitions in index order with a request/done handshake and a
// per-partition timeout, then signals valid life-cycle data or a latched abort cause.
module fc_partition_init_seq
   import fc_init_seq_pkg::*;
#(
   parameter int unsigned NUM_PARTITIONS = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned PART_IDX_W     = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1
) (
   input  logic                      core_clk,
   input  logic                      core_rst,
   input  logic                      fc_partition_init,
   input  lc_ctrl_pkg::lc_tx_t       lc_escalate_en_i,
   output logic [NUM_PARTITIONS-1:0] part_init_req_o,
   input  logic [NUM_PARTITIONS-1:0] part_init_done_i,
   input  logic [NUM_PARTITIONS-1:0] part_error_i,
   output logic                      otp_lc_data_o_valid,
   output logic                      init_error_o,
   output logic [1:0]                err_cause_o,
   output logic [PART_IDX_W-1:0]     err_part_idx_o,
   output logic                      busy_o
);

   localparam logic [PART_IDX_W-1:0] LAST_IDX = PART_IDX_W'(NUM_PARTITIONS - 1);

   fc_init_state_e              state_q, state_d;
   logic [PART_IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_PARTITIONS-1:0]   req_q, req_d;
   logic                        valid_q, valid_d;
   logic                        error_q, error_d;
   fc_init_err_e                cause_q, cause_d;
   logic [PART_IDX_W-1:0]       err_idx_q, err_idx_d;
   logic                        busy_q;

   logic                        escalate;
   logic                        abort;
   fc_init_err_e                abort_cause;
   logic                        cnt_clr;
   logic                        cnt_en;
   logic                        cnt_expired;

   assign escalate = !lc_tx_is_off(lc_escalate_en_i);

   // The counter is held at zero outside WAIT and on every partition hand-over,
   // so each partition sees a fresh budget starting from its first WAIT cycle.
   fc_init_timeout_cnt #(
      .MAX_COUNT (TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clock   (core_clk),
      .reset   (core_rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (cnt_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      req_d       = req_q;
      valid_d     = valid_q;
      error_d     = error_q;
      cause_d     = cause_q;
      err_idx_d   = err_idx_q;
      cnt_clr     = 1'b1;
      cnt_en      = 1'b0;
      abort       = 1'b0;
      abort_cause = NoErr;

      unique case (state_q)
         StIdle: begin
            if (escalate) begin
               abort       = 1'b1;
               abort_cause = Escalate;
            end else if (fc_partition_init) begin
               state_d = StWait;
               idx_d   = '0;
               req_d   = NUM_PARTITIONS'(1);
            end
         end
         StWait: begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
            // Only the partition currently addressed may advance or abort the walk.
            if (escalate) begin
               abort       = 1'b1;
               abort_cause = Escalate;
            end else if (part_error_i[idx_q]) begin
               abort       = 1'b1;
               abort_cause = PartErr;
            end else if (part_init_done_i[idx_q]) begin
               cnt_clr = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = StDone;
                  req_d   = '0;
                  valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + PART_IDX_W'(1);
                  req_d = req_q << 1;
               end
            end else if (cnt_expired) begin
               abort       = 1'b1;
               abort_cause = Timeout;
            end
         end
         StDone: begin
            if (escalate) begin
               abort       = 1'b1;
               abort_cause = Escalate;
            end
         end
         StError: begin
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort) begin
         state_d   = StError;
         req_d     = '0;
         valid_d   = 1'b0;
         error_d   = 1'b1;
         cause_d   = abort_cause;
         err_idx_d = idx_q;
      end
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         req_q     <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         cause_q   <= NoErr;
         err_idx_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         req_q     <= req_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         cause_q   <= cause_d;
         err_idx_q <= err_idx_d;
         busy_q    <= (state_d == StWait);
      end
   end

   assign part_init_req_o     = req_q;
   assign otp_lc_data_o_valid = valid_q;
   assign init_error_o        = error_q;
   assign err_cause_o         = cause_q;
   assign err_part_idx_o      = err_idx_q;
   assign busy_o              = busy_q;

endmodule

// File: tb/tb_fc_partition_init_seq.sv
// Directed and randomized checks of the partition init sequencer against a
// rule-level model of the handshake, timeout and abort outcomes.
module tb_fc_partition_init_seq;
   import lc_ctrl_pkg::*;

   localparam int NP = 4;
   localparam int TO = 8;

   logic          core_clk = 1'b0;
   logic          core_rst;
   logic          fc_partition_init;
   lc_tx_t        lc_escalate_en_i;
   logic [NP-1:0] part_init_req_o;
   logic [NP-1:0] part_init_done_i;
   logic [NP-1:0] part_error_i;
   logic          otp_lc_data_o_valid;
   logic          init_error_o;
   logic [1:0]    err_cause_o;
   logic [1:0]    err_part_idx_o;
   logic          busy_o;

   int total = 0;
   int bad   = 0;

   logic [NP-1:0] exp_req;
   logic          exp_valid;
   logic          exp_err;
   logic [1:0]    exp_cause;
   logic [1:0]    exp_idx;
   logic          exp_busy;

   fc_partition_init_seq #(
      .NUM_PARTITIONS (NP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .core_clk            (core_clk),
      .core_rst            (core_rst),
      .fc_partition_init   (fc_partition_init),
      .lc_escalate_en_i    (lc_escalate_en_i),
      .part_init_req_o     (part_init_req_o),
      .part_init_done_i    (part_init_done_i),
      .part_error_i        (part_error_i),
      .otp_lc_data_o_valid (otp_lc_data_o_valid),
      .init_error_o        (init_error_o),
      .err_cause_o         (err_cause_o),
      .err_part_idx_o      (err_part_idx_o),
      .busy_o              (busy_o)
   );

   always #5 core_clk = ~core_clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic lc_tx_t randEsc();
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      if (v == 4'b1010) v = 4'b0101;
      return lc_tx_t'(v);
   endfunction

   task automatic step();
      @(posedge core_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".req"},   32'(part_init_req_o),     32'(exp_req));
      checkOutput({tag, ".valid"}, 32'(otp_lc_data_o_valid), 32'(exp_valid));
      checkOutput({tag, ".err"},   32'(init_error_o),        32'(exp_err));
      checkOutput({tag, ".cause"}, 32'(err_cause_o),         32'(exp_cause));
      checkOutput({tag, ".idx"},   32'(err_part_idx_o),      32'(exp_idx));
      checkOutput({tag, ".busy"},  32'(busy_o),              32'(exp_busy));
   endtask

   task automatic expectAbort(input int cause, input int idx);
      exp_req   = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b1;
      exp_cause = 2'(cause);
      exp_idx   = 2'(idx);
      exp_busy  = 1'b0;
   endtask

   task automatic doReset();
      core_rst          = 1'b1;
      fc_partition_init = 1'b0;
      lc_escalate_en_i  = Off;
      part_init_done_i  = '0;
      part_error_i      = '0;
      step();
      exp_req = '0; exp_valid = 1'b0; exp_err = 1'b0;
      exp_cause = 2'd0; exp_idx = 2'd0; exp_busy = 1'b0;
      checkState("reset");
      core_rst = 1'b0;
   endtask

   // Partition p answers at the j-th edge after its request rose: error beats done,
   // done beats timeout, and an unanswered partition aborts at edge TO.
   task automatic applyStimulus(input string tag, input int dly[NP], input int err_at[NP],
                                input int esc_p, input int esc_j, input bit drop_init,
                                input bit noise);
      logic [NP-1:0] mask;
      bit            finished;
      bit            esc_now;
      fc_partition_init = 1'b1;
      lc_escalate_en_i  = Off;
      part_init_done_i  = '0;
      part_error_i      = '0;
      step();
      exp_req = 4'b0001; exp_busy = 1'b1; exp_valid = 1'b0;
      exp_err = 1'b0; exp_cause = 2'd0; exp_idx = 2'd0;
      checkState({tag, ".start"});
      finished = 1'b0;
      for (int p = 0; p < NP && !finished; p++) begin
         if (drop_init && p == 1) fc_partition_init = 1'b0;
         mask = NP'(1) << p;
         for (int j = 1; j <= TO; j++) begin
            esc_now          = (p == esc_p) && (j == esc_j);
            part_init_done_i = noise ? (NP'($urandom) & ~mask) : '0;
            part_error_i     = noise ? (NP'($urandom) & ~mask) : '0;
            if (j == dly[p])    part_init_done_i = part_init_done_i | mask;
            if (j == err_at[p]) part_error_i     = part_error_i | mask;
            lc_escalate_en_i = esc_now ? randEsc() : Off;
            step();
            if (esc_now) begin
               expectAbort(3, p);
               finished = 1'b1;
            end else if (j == err_at[p]) begin
               expectAbort(1, p);
               finished = 1'b1;
            end else if (j == dly[p]) begin
               if (p == NP - 1) begin
                  exp_req   = '0;
                  exp_busy  = 1'b0;
                  exp_valid = 1'b1;
               end else begin
                  exp_req = mask << 1;
               end
            end else if (j == TO) begin
               expectAbort(2, p);
               finished = 1'b1;
            end
            checkState($sformatf("%s.p%0d.c%0d", tag, p, j));
            if (finished || j == dly[p]) break;
         end
      end
      part_init_done_i = '0;
      part_error_i     = '0;
      lc_escalate_en_i = Off;
   endtask

   // DONE and ERROR must ignore handshake noise and a re-asserted init request.
   task automatic holdTerminal(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         fc_partition_init = 1'b1;
         part_init_done_i  = NP'($urandom);
         part_error_i      = NP'($urandom);
         lc_escalate_en_i  = Off;
         step();
         checkState({tag, ".hold"});
      end
      part_init_done_i = '0;
      part_error_i     = '0;
   endtask

   initial begin
      int dly[NP];
      int err_at[NP];
      int esc_p;
      int esc_j;

      doReset();

      $display("[TB] escalation from idle");
      lc_escalate_en_i = randEsc();
      step();
      expectAbort(3, 0);
      checkState("esc_idle");
      holdTerminal("esc_idle", 2);

      $display("[TB] nominal walk, 3-cycle responses");
      doReset();
      applyStimulus("nominal3", '{3, 3, 3, 3}, '{0, 0, 0, 0}, -1, 0, 1'b0, 1'b1);
      holdTerminal("nominal3", 3);

      $display("[TB] best-case walk, 1-cycle responses");
      doReset();
      applyStimulus("fast", '{1, 1, 1, 1}, '{0, 0, 0, 0}, -1, 0, 1'b0, 1'b0);

      $display("[TB] escalation in done");
      lc_escalate_en_i = On;
      step();
      expectAbort(3, 3);
      checkState("esc_done");
      lc_escalate_en_i = Off;
      part_init_done_i = 4'b0001;
      step();
      checkState("esc_done.stray");
      part_init_done_i = '0;

      $display("[TB] error and done together on partition 2");
      doReset();
      applyStimulus("perr2", '{2, 1, 4, 1}, '{0, 0, 4, 0}, -1, 0, 1'b0, 1'b1);
      holdTerminal("perr2", 2);

      $display("[TB] partition 1 never answers");
      doReset();
      applyStimulus("tmo1", '{2, 0, 1, 1}, '{0, 0, 0, 0}, -1, 0, 1'b0, 1'b1);
      holdTerminal("tmo1", 2);

      $display("[TB] done on the last cycle before timeout");
      doReset();
      applyStimulus("edge8", '{8, 1, 8, 2}, '{0, 0, 0, 0}, -1, 0, 1'b0, 1'b1);

      $display("[TB] stray done[3] at idx 0 and init dropped at idx 1");
      doReset();
      fc_partition_init = 1'b1;
      step();
      part_init_done_i = 4'b1000;
      step();
      exp_req = 4'b0001; exp_busy = 1'b1; exp_valid = 1'b0;
      exp_err = 1'b0; exp_cause = 2'd0; exp_idx = 2'd0;
      checkState("stray3");
      doReset();
      applyStimulus("drop", '{2, 3, 1, 2}, '{0, 0, 0, 0}, -1, 0, 1'b1, 1'b1);

      $display("[TB] reset mid-wait at idx 2");
      doReset();
      fc_partition_init = 1'b1;
      step();
      part_init_done_i = 4'b0001;
      step();
      part_init_done_i = 4'b0010;
      step();
      part_init_done_i = '0;
      exp_req = 4'b0100; exp_busy = 1'b1; exp_valid = 1'b0;
      exp_err = 1'b0; exp_cause = 2'd0; exp_idx = 2'd0;
      checkState("mid_idx2");
      core_rst = 1'b1;
      step();
      exp_req = '0; exp_busy = 1'b0;
      checkState("mid_rst");
      core_rst = 1'b0;
      step();
      exp_req = 4'b0001; exp_busy = 1'b1;
      checkState("restart");

      $display("[TB] randomized sequences");
      for (int it = 0; it < 12; it++) begin
         for (int p = 0; p < NP; p++) begin
            dly[p]    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            err_at[p] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TO)) : 0;
         end
         esc_p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
         esc_j = int'($urandom_range(1, TO));
         doReset();
         applyStimulus($sformatf("rand%0d", it), dly, err_at, esc_p, esc_j,
                       1'($urandom_range(0, 1)), 1'b1);
         holdTerminal($sformatf("rand%0d", it), 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
